// File: rtl/boson_pkg.sv
// Shared definitions for the Boson parallel-video pattern generator.
// Declarations only: adds no logic and no latency.
// No flow control lives here; the generator is free-running while enabled.
package boson_pkg;

   // Runtime pattern selection, sampled once per frame.
   typedef enum logic [1:0] {
      MODE_HRAMP   = 2'd0,
      MODE_VRAMP   = 2'd1,
      MODE_CHECK   = 2'd2,
      MODE_FRAMEID = 2'd3
   } mode_e;

   // Top-level run state.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Native Boson 640x512 geometry.
   localparam int BOSON_H_ACTIVE  = 640;
   localparam int BOSON_H_BLANK   = 160;
   localparam int BOSON_HSYNC_LEN = 8;
   localparam int BOSON_V_ACTIVE  = 512;
   localparam int BOSON_V_BLANK   = 20;
   localparam int BOSON_VSYNC_LEN = 2;

   // Electrical level of a sync line given its logical state and polarity.
   function automatic logic sync_level(input logic active, input logic pol);
      return ~(active ^ pol);
   endfunction

endpackage

// File: rtl/boson_timing_ctr.sv
// Horizontal/vertical raster counters with registered sync, valid and coordinate decode.
// Latency: decode outputs lag the counter position by one cycle.
// No backpressure: counters advance every cycle while run is high.
module boson_timing_ctr
   import boson_pkg::*;
#(
   parameter int H_ACTIVE  = BOSON_H_ACTIVE,
   parameter int H_BLANK   = BOSON_H_BLANK,
   parameter int HSYNC_LEN = BOSON_HSYNC_LEN,
   parameter int V_ACTIVE  = BOSON_V_ACTIVE,
   parameter int V_BLANK   = BOSON_V_BLANK,
   parameter int VSYNC_LEN = BOSON_VSYNC_LEN,
   parameter int HW        = $clog2(H_BLANK + H_ACTIVE),
   parameter int VW        = $clog2(V_BLANK + V_ACTIVE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run,
   input  logic          clear,
   output logic [HW-1:0] x,
   output logic [VW-1:0] y,
   output logic          vsync_act,
   output logic          hsync_act,
   output logic          valid,
   output logic          live,
   output logic          frame_last,
   output logic          end_of_frame
);

   localparam logic [HW-1:0] H_LAST    = HW'(H_BLANK + H_ACTIVE - 1);
   localparam logic [VW-1:0] V_LAST    = VW'(V_BLANK + V_ACTIVE - 1);
   localparam logic [HW-1:0] H_BLANK_C = HW'(H_BLANK);
   localparam logic [VW-1:0] V_BLANK_C = VW'(V_BLANK);
   localparam logic [HW-1:0] HSYNC_C   = HW'(HSYNC_LEN);
   localparam logic [VW-1:0] VSYNC_C   = VW'(VSYNC_LEN);

   logic [HW-1:0] h;
   logic [VW-1:0] v;

   // Last raster position of the frame, seen by the FSM in the same cycle.
   assign end_of_frame = run && (h == H_LAST) && (v == V_LAST);

   // Raster position: h sweeps each line, v steps once per line and wraps per frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h <= '0;
         v <= '0;
      end else if (clear) begin
         h <= '0;
         v <= '0;
      end else if (run) begin
         if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + VW'(1);
         end else begin
            h <= h + HW'(1);
         end
      end
   end

   // Decode stage; every flag is qualified by run so an idle raster reads as inactive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x          <= '0;
         y          <= '0;
         vsync_act  <= 1'b0;
         hsync_act  <= 1'b0;
         valid      <= 1'b0;
         live       <= 1'b0;
         frame_last <= 1'b0;
      end else begin
         x          <= h - H_BLANK_C;
         y          <= v - V_BLANK_C;
         vsync_act  <= run && (v < VSYNC_C);
         hsync_act  <= run && (h < HSYNC_C);
         valid      <= run && (h >= H_BLANK_C) && (v >= V_BLANK_C);
         live       <= run;
         frame_last <= end_of_frame;
      end
   end

endmodule

// File: rtl/boson_pattern_gen.sv
// Boson 16-bit parallel video source: raster timing, four test patterns, frame counter.
// Latency: first vsync appears two edges after enable is sampled; outputs are registered.
// No backpressure: once started, a frame always runs to completion at one pixel per clock.
module boson_pattern_gen
   import boson_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int H_ACTIVE   = BOSON_H_ACTIVE,
   parameter int H_BLANK    = BOSON_H_BLANK,
   parameter int HSYNC_LEN  = BOSON_HSYNC_LEN,
   parameter int V_ACTIVE   = BOSON_V_ACTIVE,
   parameter int V_BLANK    = BOSON_V_BLANK,
   parameter int VSYNC_LEN  = BOSON_VSYNC_LEN,
   parameter int SYNC_POL   = 1,
   parameter int CHECK_LOG2 = 3,
   parameter int FCNT_W     = 16
) (
   input  logic              wb_clk,
   input  logic              wb_rst,
   input  logic              enable,
   input  logic [1:0]        mode,
   output logic [DATA_W-1:0] cmos_dq,
   output logic              cmos_vsync,
   output logic              cmos_hsync,
   output logic              cmos_valid,
   output logic              frame_done,
   output logic [FCNT_W-1:0] frame_count,
   output logic              busy
);

   localparam int HW = $clog2(H_BLANK + H_ACTIVE);
   localparam int VW = $clog2(V_BLANK + V_ACTIVE);
   localparam logic POL = (SYNC_POL != 0);

   // Select the checker bit of each coordinate; a square wider than the raster
   // shifts the mask out entirely and the bit simply reads as zero.
   localparam logic [HW-1:0] X_CHK_MASK = HW'(1) << CHECK_LOG2;
   localparam logic [VW-1:0] Y_CHK_MASK = VW'(1) << CHECK_LOG2;

   state_e state;
   state_e state_nx;
   mode_e  mode_cur;
   mode_e  mode_pipe;
   logic   run;
   logic   clear;
   logic   mode_load;
   logic   eof;

   logic [HW-1:0] x;
   logic [VW-1:0] y;
   logic          vs_act;
   logic          hs_act;
   logic          vld;
   logic          live;
   logic          flast;

   logic              chk_x;
   logic              chk_y;
   logic [DATA_W-1:0] pattern;

   assign clear = (state == IDLE);

   boson_timing_ctr #(
      .H_ACTIVE  (H_ACTIVE),
      .H_BLANK   (H_BLANK),
      .HSYNC_LEN (HSYNC_LEN),
      .V_ACTIVE  (V_ACTIVE),
      .V_BLANK   (V_BLANK),
      .VSYNC_LEN (VSYNC_LEN),
      .HW        (HW),
      .VW        (VW)
   ) u_timing (
      .clk          (wb_clk),
      .rst          (wb_rst),
      .run          (run),
      .clear        (clear),
      .x            (x),
      .y            (y),
      .vsync_act    (vs_act),
      .hsync_act    (hs_act),
      .valid        (vld),
      .live         (live),
      .frame_last   (flast),
      .end_of_frame (eof)
   );

   // Run control: start on enable, decide continue/stop only at the last cycle of a frame.
   always_comb begin
      state_nx  = state;
      run       = 1'b0;
      mode_load = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               state_nx  = RUN;
               mode_load = 1'b1;
            end
         end
         RUN: begin
            run = 1'b1;
            if (eof) begin
               if (enable) begin
                  mode_load = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and per-frame mode; mode_pipe realigns the mode with the decode stage so the
   // last pixel of a frame is still rendered with that frame's mode.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         state     <= IDLE;
         mode_cur  <= MODE_HRAMP;
         mode_pipe <= MODE_HRAMP;
      end else begin
         state     <= state_nx;
         mode_pipe <= mode_cur;
         if (mode_load) begin
            mode_cur <= mode_e'(mode);
         end
      end
   end

   assign chk_x = |(x & X_CHK_MASK);
   assign chk_y = |(y & Y_CHK_MASK);

   // Pattern mux; frame_count here still holds the index of the frame being drawn.
   always_comb begin
      pattern = '0;
      case (mode_pipe)
         MODE_HRAMP:   pattern = DATA_W'(x);
         MODE_VRAMP:   pattern = DATA_W'(y);
         MODE_CHECK:   pattern = {DATA_W{chk_x ^ chk_y}};
         MODE_FRAMEID: pattern = DATA_W'(frame_count);
         default:      pattern = '0;
      endcase
   end

   // Output registers; the frame counter steps on the edge that shows the last pixel.
   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         cmos_dq     <= '0;
         cmos_vsync  <= ~POL;
         cmos_hsync  <= ~POL;
         cmos_valid  <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         busy        <= 1'b0;
      end else begin
         cmos_dq     <= vld ? pattern : '0;
         cmos_vsync  <= sync_level(vs_act, POL);
         cmos_hsync  <= sync_level(hs_act, POL);
         cmos_valid  <= vld;
         frame_done  <= flast;
         busy        <= live;
         if (flast) begin
            frame_count <= frame_count + FCNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_boson_pattern_gen.sv
`timescale 1ns/1ps
module tb_boson_pattern_gen;
   import boson_pkg::*;

   typedef struct packed {
      logic        vs;
      logic        hs;
      logic        vld;
      logic [15:0] dq;
      logic        done;
      logic [3:0]  fcnt;
      logic        busy;
   } obs_t;

   typedef struct {
      logic en;
      obs_t exp;
   } vec_t;

   logic        wb_clk;
   logic        wb_rst;
   logic        en_ab;
   logic        en_c;
   logic [1:0]  mode_ab;
   logic [1:0]  mode_c;

   logic [15:0] a_dq, b_dq, c_dq;
   logic        a_vs, a_hs, a_vld, a_done, a_busy;
   logic        b_vs, b_hs, b_vld, b_done, b_busy;
   logic        c_vs, c_hs, c_vld, c_done, c_busy;
   logic [3:0]  a_fcnt, b_fcnt, c_fcnt;

   int n_cmp = 0;
   int n_bad = 0;

   vec_t        tv[25];
   logic [15:0] pix[$];

   // A: small raster, active-high syncs.
   boson_pattern_gen #(
      .DATA_W(16), .H_ACTIVE(4), .H_BLANK(3), .HSYNC_LEN(1), .V_ACTIVE(2), .V_BLANK(1),
      .VSYNC_LEN(1), .SYNC_POL(1), .CHECK_LOG2(3), .FCNT_W(4)
   ) dut_a (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(en_ab), .mode(mode_ab),
      .cmos_dq(a_dq), .cmos_vsync(a_vs), .cmos_hsync(a_hs), .cmos_valid(a_vld),
      .frame_done(a_done), .frame_count(a_fcnt), .busy(a_busy)
   );

   // B: same raster, active-low syncs, same stimulus as A.
   boson_pattern_gen #(
      .DATA_W(16), .H_ACTIVE(4), .H_BLANK(3), .HSYNC_LEN(1), .V_ACTIVE(2), .V_BLANK(1),
      .VSYNC_LEN(1), .SYNC_POL(0), .CHECK_LOG2(3), .FCNT_W(4)
   ) dut_b (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(en_ab), .mode(mode_ab),
      .cmos_dq(b_dq), .cmos_vsync(b_vs), .cmos_hsync(b_hs), .cmos_valid(b_vld),
      .frame_done(b_done), .frame_count(b_fcnt), .busy(b_busy)
   );

   // C: 4x4 active area with 2-pixel checker squares.
   boson_pattern_gen #(
      .DATA_W(16), .H_ACTIVE(4), .H_BLANK(3), .HSYNC_LEN(1), .V_ACTIVE(4), .V_BLANK(1),
      .VSYNC_LEN(1), .SYNC_POL(1), .CHECK_LOG2(1), .FCNT_W(4)
   ) dut_c (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(en_c), .mode(mode_c),
      .cmos_dq(c_dq), .cmos_vsync(c_vs), .cmos_hsync(c_hs), .cmos_valid(c_vld),
      .frame_done(c_done), .frame_count(c_fcnt), .busy(c_busy)
   );

   initial begin
      wb_clk = 1'b0;
      forever #5 wb_clk = ~wb_clk;
   end

   task automatic step();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic check(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %h, want %h", name, idx, got, want);
      end
   endtask

   function automatic obs_t mk(int vs, int hs, int vld, int dq, int done, int fc, int busy);
      obs_t o;
      o.vs   = (vs != 0);
      o.hs   = (hs != 0);
      o.vld  = (vld != 0);
      o.dq   = 16'(dq);
      o.done = (done != 0);
      o.fcnt = 4'(fc);
      o.busy = (busy != 0);
      return o;
   endfunction

   function automatic obs_t inv_sync(obs_t o);
      obs_t r;
      r    = o;
      r.vs = ~o.vs;
      r.hs = ~o.hs;
      return r;
   endfunction

   function automatic obs_t obs_a();
      return {a_vs, a_hs, a_vld, a_dq, a_done, a_fcnt, a_busy};
   endfunction

   function automatic obs_t obs_b();
      return {b_vs, b_hs, b_vld, b_dq, b_done, b_fcnt, b_busy};
   endfunction

   function automatic obs_t obs_c();
      return {c_vs, c_hs, c_vld, c_dq, c_done, c_fcnt, c_busy};
   endfunction

   task automatic set(int i, int en, int vs, int hs, int vld, int dq, int done, int fc, int busy);
      tv[i].en  = (en != 0);
      tv[i].exp = mk(vs, hs, vld, dq, done, fc, busy);
   endtask

   initial begin
      int          dones;
      int          gap;
      int          vs_cyc;
      int          fdone;
      int          fc16;
      int          fc17;
      int          f16_n, f16_bad, f17_n, f17_bad;
      logic [15:0] exp2[16];
      logic [15:0] exp3[16];

      // Row i: enable driven before edge i, expected outputs just after edge i.
      //     i  en vs hs vld dq done fc busy
      set( 0, 1, 0, 0, 0, 0, 0, 0, 0);
      set( 1, 0, 0, 0, 0, 0, 0, 0, 0);
      set( 2, 0, 1, 1, 0, 0, 0, 0, 1);
      set( 3, 0, 1, 0, 0, 0, 0, 0, 1);
      set( 4, 0, 1, 0, 0, 0, 0, 0, 1);
      set( 5, 0, 1, 0, 0, 0, 0, 0, 1);
      set( 6, 0, 1, 0, 0, 0, 0, 0, 1);
      set( 7, 0, 1, 0, 0, 0, 0, 0, 1);
      set( 8, 0, 1, 0, 0, 0, 0, 0, 1);
      set( 9, 0, 0, 1, 0, 0, 0, 0, 1);
      set(10, 0, 0, 0, 0, 0, 0, 0, 1);
      set(11, 0, 0, 0, 0, 0, 0, 0, 1);
      set(12, 0, 0, 0, 1, 0, 0, 0, 1);
      set(13, 0, 0, 0, 1, 1, 0, 0, 1);
      set(14, 0, 0, 0, 1, 2, 0, 0, 1);
      set(15, 0, 0, 0, 1, 3, 0, 0, 1);
      set(16, 0, 0, 1, 0, 0, 0, 0, 1);
      set(17, 0, 0, 0, 0, 0, 0, 0, 1);
      set(18, 0, 0, 0, 0, 0, 0, 0, 1);
      set(19, 0, 0, 0, 1, 0, 0, 0, 1);
      set(20, 0, 0, 0, 1, 1, 0, 0, 1);
      set(21, 0, 0, 0, 1, 2, 0, 0, 1);
      set(22, 0, 0, 0, 1, 3, 1, 1, 1);
      set(23, 0, 0, 0, 0, 0, 0, 1, 0);
      set(24, 0, 0, 0, 0, 0, 0, 1, 0);

      exp2 = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3,
               16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1};
      exp3 = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF,
               16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF,
               16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
               16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};

      // Reset state.
      wb_rst  = 1'b0;
      en_ab   = 1'b0;
      en_c    = 1'b0;
      mode_ab = MODE_HRAMP;
      mode_c  = MODE_HRAMP;
      #2 wb_rst = 1'b1;
      step();
      step();
      check("reset_a", 0, {7'd0, obs_a()}, {7'd0, mk(0, 0, 0, 0, 0, 0, 0)});
      check("reset_b", 0, {7'd0, obs_b()}, {7'd0, mk(1, 1, 0, 0, 0, 0, 0)});
      check("reset_c", 0, {7'd0, obs_c()}, {7'd0, mk(0, 0, 0, 0, 0, 0, 0)});
      wb_rst = 1'b0;

      // Single frame from a one-cycle enable pulse; B must match with syncs inverted.
      for (int i = 0; i < 25; i++) begin
         en_ab   = tv[i].en;
         mode_ab = MODE_HRAMP;
         step();
         check("single_a", i, {7'd0, obs_a()}, {7'd0, tv[i].exp});
         check("single_pol0_b", i, {7'd0, obs_b()}, {7'd0, inv_sync(tv[i].exp)});
      end

      // Two back-to-back frames, mode switched to vertical ramp during frame 1.
      pix.delete();
      dones  = 0;
      gap    = 0;
      vs_cyc = 0;
      en_ab  = 1'b1;
      for (int i = 0; i < 48; i++) begin
         if (i == 10) mode_ab = MODE_VRAMP;
         if (i == 30) en_ab = 1'b0;
         step();
         if (a_vld) pix.push_back(a_dq);
         if (a_done) dones++;
         if (a_vs) vs_cyc++;
         if (i >= 2 && i <= 43 && !a_busy) gap++;
      end
      check("cont_pix_count", 0, 32'(pix.size()), 32'd16);
      for (int i = 0; i < 16; i++) begin
         if (i < pix.size()) check("cont_pix", i, {16'd0, pix[i]}, {16'd0, exp2[i]});
      end
      check("cont_done_pulses", 0, 32'(dones), 32'd2);
      check("cont_busy_gap", 0, 32'(gap), 32'd0);
      check("cont_vsync_cycles", 0, 32'(vs_cyc), 32'd14);
      check("cont_fcnt", 0, {28'd0, a_fcnt}, 32'd3);
      check("cont_busy_end", 0, {31'd0, a_busy}, 32'd0);

      // Checkerboard on the 4x4 instance.
      pix.delete();
      dones  = 0;
      en_c   = 1'b1;
      mode_c = MODE_CHECK;
      for (int i = 0; i < 40; i++) begin
         if (i == 1) en_c = 1'b0;
         step();
         if (c_vld) pix.push_back(c_dq);
         if (c_done) dones++;
      end
      check("check_pix_count", 0, 32'(pix.size()), 32'd16);
      for (int i = 0; i < 16; i++) begin
         if (i < pix.size()) check("check_pix", i, {16'd0, pix[i]}, {16'd0, exp3[i]});
      end
      check("check_done", 0, 32'(dones), 32'd1);
      check("check_fcnt", 0, {28'd0, c_fcnt}, 32'd1);
      check("check_busy_end", 0, {31'd0, c_busy}, 32'd0);

      // Frame-id pattern across the 4-bit counter wrap.
      wb_rst = 1'b1;
      step();
      wb_rst  = 1'b0;
      en_ab   = 1'b1;
      mode_ab = MODE_FRAMEID;
      fdone   = 0;
      fc16    = -1;
      fc17    = -1;
      f16_n   = 0;
      f16_bad = 0;
      f17_n   = 0;
      f17_bad = 0;
      for (int i = 0; i < 370; i++) begin
         step();
         if (a_vld) begin
            if (fdone == 15) begin
               f16_n++;
               if (a_dq !== 16'd15) f16_bad++;
            end
            if (fdone == 16) begin
               f17_n++;
               if (a_dq !== 16'd0) f17_bad++;
            end
         end
         if (a_done) begin
            fdone++;
            if (fdone == 16) begin
               fc16  = int'(a_fcnt);
               en_ab = 1'b0;
            end
            if (fdone == 17) fc17 = int'(a_fcnt);
         end
      end
      check("fid_frames", 0, 32'(fdone), 32'd17);
      check("fid_f16_pixels", 0, 32'(f16_n), 32'd8);
      check("fid_f16_not15", 0, 32'(f16_bad), 32'd0);
      check("fid_f17_pixels", 0, 32'(f17_n), 32'd8);
      check("fid_f17_not0", 0, 32'(f17_bad), 32'd0);
      check("fid_fcnt_after16", 0, 32'(fc16), 32'd0);
      check("fid_fcnt_after17", 0, 32'(fc17), 32'd1);
      check("fid_busy_end", 0, {31'd0, a_busy}, 32'd0);

      // Enable dropped during line 1: frame still completes.
      pix.delete();
      dones   = 0;
      en_ab   = 1'b1;
      mode_ab = MODE_HRAMP;
      for (int i = 0; i < 30; i++) begin
         if (i == 13) en_ab = 1'b0;
         step();
         if (a_vld) pix.push_back(a_dq);
         if (a_done) dones++;
      end
      check("stop_pixels", 0, 32'(pix.size()), 32'd8);
      check("stop_done", 0, 32'(dones), 32'd1);
      check("stop_fcnt", 0, {28'd0, a_fcnt}, 32'd2);
      check("stop_busy_end", 0, {31'd0, a_busy}, 32'd0);

      // Reset asserted mid-frame: outputs drop without waiting for a clock edge.
      en_ab = 1'b1;
      step();
      en_ab = 1'b0;
      for (int i = 1; i <= 13; i++) step();
      check("pre_rst_valid", 0, {31'd0, a_vld}, 32'd1);
      wb_rst = 1'b1;
      #1;
      check("async_rst_a", 0, {7'd0, obs_a()}, {7'd0, mk(0, 0, 0, 0, 0, 0, 0)});
      check("async_rst_b", 0, {7'd0, obs_b()}, {7'd0, mk(1, 1, 0, 0, 0, 0, 0)});
      dones = 0;
      step();
      if (a_done) dones++;
      step();
      if (a_done) dones++;
      wb_rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (a_done) dones++;
      end
      check("rst_no_done", 0, 32'(dones), 32'd0);
      check("rst_fcnt", 0, {28'd0, a_fcnt}, 32'd0);
      check("rst_busy", 0, {31'd0, a_busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
